pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush sequencer for the five-stage pipeline.
- Inputs: hazard and redirect requests from ID, EX and MEM.
- Outputs: per-register hold (stall) and clear (flush) controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB, plus a PC-redirect port.
- Internal sequencing: a three-state FSM and a countdown for multi-cycle EX operations, so every pipeline register shares one consistent control source.

## Interface
Parameters:
- CNT_W, 6, width of multi-cycle length and countdown
- EXC_VECTOR, 32'h0000_0040, PC loaded on exception

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_load_use  in  1  ID detected load-use hazard (level)
- ex_mc_start  in  1  EX begins multi-cycle op (one-cycle pulse)
- ex_mc_len  in  CNT_W  total stall cycles requested by that op
- ex_branch_taken  in  1  branch/jump resolved taken in EX
- ex_branch_target  in  32  redirect address for taken branch
- mem_exc_req  in  1  exception raised in MEM (one-cycle pulse)
- stall  out  5  hold enables: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB
- flush  out  4  clear enables: [0] IF/ID, [1] ID/EX, [2] EX/MEM, [3] MEM/WB
- new_pc_valid  out  1  PC must load new_pc at next edge
- new_pc  out  32  redirect address
- busy  out  1  FSM not in RUN
- stall_cnt  out  32  count of cycles with stall[0]=1, saturating

## Operation
- **Register semantics at the consumer:**
  - A flushed register loads zero at the next edge.
  - A stalled register holds its value.
  - Flush overrides stall on the same register.
- **FSM states:** RUN, MC_BUSY, EXC_REDIR. stall, flush and new_pc are combinational from state plus the current inputs.
- **Request priority, highest first:** mem_exc_req, then MC (start or MC_BUSY), then ex_branch_taken, then id_load_use. Lower-priority requests in the same cycle are ignored.
- **mem_exc_req (any state):**
  - flush=4'b0111, stall[0]=1.
  - Next state EXC_REDIR; the countdown is cleared, aborting any MC op.
- **EXC_REDIR:**
  - new_pc_valid=1, new_pc=EXC_VECTOR, flush=4'b0011.
  - Next state RUN, unless mem_exc_req=1, in which case it stays EXC_REDIR.
- **ex_mc_start in RUN with L=ex_mc_len:**
  - L=0: no effect.
  - L≥1: stall=5'b00111 and flush[2]=1 (bubble into EX/MEM) for exactly L cycles, counting the start cycle.
  - Countdown loads L-1. If L-1≠0, next state is MC_BUSY.
- **MC_BUSY:**
  - Same stall/flush as the start cycle.
  - Countdown decrements each cycle; the cycle with count==1 is the last, and the next state is RUN.
  - ex_mc_start is ignored while in MC_BUSY.
- **ex_branch_taken (RUN, no higher request):**
  - new_pc_valid=1, new_pc=ex_branch_target, flush=4'b0011, stall=0.
  - No state change.
- **id_load_use (RUN, no higher request):** stall=5'b00011, flush=4'b0010, i.e. one bubble per asserted cycle.
- **Idle outputs:** with no request, stall=0, flush=0, new_pc_valid=0 and new_pc=0.
- **stall_cnt:** increments on each edge where stall[0]=1; saturates at 32'hFFFF_FFFF.
- **busy:** 1 in MC_BUSY and EXC_REDIR.

## Timing
- **Reset:**
  - Asynchronous; takes effect immediately.
  - State=RUN, countdown=0, stall_cnt=0.
  - With inputs low, all outputs are 0.
  - Reset during MC_BUSY or EXC_REDIR aborts the sequence with no redirect.
- **Latency:**
  - Load-use, branch and exception-kill controls are zero-latency (same cycle as the request).
  - The exception redirect appears exactly one cycle after mem_exc_req.
- **MC stall length:** exactly L cycles. busy rises the cycle after start when L≥2 and falls one cycle after the last stall cycle.
- **No combinational path** from any output back to any input.

## Test plan
- **Reset:** assert rst mid-MC (L=5, third cycle) -> stall=0, flush=0, busy=0, stall_cnt=0 immediately; no redirect after release.
- **Load-use:** id_load_use high for 2 cycles -> stall=5'b00011 and flush=4'b0010 in both cycles; stall_cnt=2.
- **MC lengths:**
  - ex_mc_start, L=4 -> stall=5'b00111 for 4 consecutive cycles, busy high for cycles 2–4, then RUN.
  - L=1 -> one stall cycle, busy never high.
  - L=0 -> no stall.
- **Branch over load-use:** ex_branch_taken with target 32'h0000_1000 and id_load_use in the same cycle -> new_pc_valid=1, new_pc=32'h0000_1000, flush=4'b0011, stall=0.
- **Exception during MC:** mem_exc_req during MC_BUSY (L=6, cycle 3) -> that cycle flush=4'b0111; next cycle new_pc=32'h0000_0040, new_pc_valid=1, flush=4'b0011; then RUN with stall=0.
- **Counter saturation:** preload stall_cnt to 32'hFFFF_FFFE via a long stall sequence or force, then 3 stall cycles -> saturates at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush sequencer: one control source for every pipeline register.
// Latency: kill/stall/branch controls are combinational (same cycle); exception redirect follows one cycle later.
// Backpressure: MC ops hold PC..ID/EX for L cycles; exceptions pre-empt everything.
module pipe_hazard_ctrl #(
    parameter int          CNT_W      = 6,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0040
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_load_use,
    input  logic             ex_mc_start,
    input  logic [CNT_W-1:0] ex_mc_len,
    input  logic             ex_branch_taken,
    input  logic [31:0]      ex_branch_target,
    input  logic             mem_exc_req,
    output logic [4:0]       stall,
    output logic [3:0]       flush,
    output logic             new_pc_valid,
    output logic [31:0]      new_pc,
    output logic             busy,
    output logic [31:0]      stall_cnt
);

    typedef enum logic [1:0] {
        S_RUN       = 2'd0,
        S_MC_BUSY   = 2'd1,
        S_EXC_REDIR = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [31:0]      stall_cnt_q, stall_cnt_d;

    // Request arbitration: exception > multi-cycle op > branch > load-use.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        stall        = 5'b00000;
        flush        = 4'b0000;
        new_pc_valid = 1'b0;
        new_pc       = 32'h0000_0000;
        if (mem_exc_req) begin
            // Kill IF/ID, ID/EX, EX/MEM; freeze PC until the redirect lands.
            // A repeated exception in EXC_REDIR also wins over the redirect.
            flush    = 4'b0111;
            stall[0] = 1'b1;
            cnt_d    = '0;
            state_d  = S_EXC_REDIR;
        end else begin
            case (state_q)
                S_EXC_REDIR: begin
                    new_pc_valid = 1'b1;
                    new_pc       = EXC_VECTOR;
                    flush        = 4'b0011;
                    state_d      = S_RUN;
                end
                S_MC_BUSY: begin
                    stall = 5'b00111;
                    flush = 4'b0100;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_RUN;
                    end
                end
                default: begin
                    if (ex_mc_start && (ex_mc_len != '0)) begin
                        // Start cycle counts as the first of L stall cycles.
                        stall = 5'b00111;
                        flush = 4'b0100;
                        cnt_d = ex_mc_len - CNT_W'(1);
                        if (cnt_d != '0) begin
                            state_d = S_MC_BUSY;
                        end
                    end else if (ex_branch_taken) begin
                        new_pc_valid = 1'b1;
                        new_pc       = ex_branch_target;
                        flush        = 4'b0011;
                    end else if (id_load_use) begin
                        stall = 5'b00011;
                        flush = 4'b0010;
                    end
                end
            endcase
        end
    end

    // Registered busy flag and saturating PC-stall counter.
    always_comb begin
        busy_d      = (state_d != S_RUN);
        stall_cnt_d = stall_cnt_q;
        if (stall[0] && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // FSM state, countdown and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_RUN;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            stall_cnt_q <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign busy      = busy_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios then random traffic vs. a cycle model.
// Model tracks "remaining MC stall cycles" and "redirect pending" rather than FSM state.
// Inputs change 1 time unit after the rising edge; outputs are checked before the next edge.
module tb_pipe_hazard_ctrl;

    localparam int          CNT_W  = 6;
    localparam logic [31:0] EXCV   = 32'h0000_0040;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_load_use;
    logic             ex_mc_start;
    logic [CNT_W-1:0] ex_mc_len;
    logic             ex_branch_taken;
    logic [31:0]      ex_branch_target;
    logic             mem_exc_req;
    logic [4:0]       stall;
    logic [3:0]       flush;
    logic             new_pc_valid;
    logic [31:0]      new_pc;
    logic             busy;
    logic [31:0]      stall_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    int          m_mc_rem;
    bit          m_redir;
    logic [31:0] m_cnt;

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .EXC_VECTOR(EXCV)) dut (
        .clk              (clk),
        .rst              (rst),
        .id_load_use      (id_load_use),
        .ex_mc_start      (ex_mc_start),
        .ex_mc_len        (ex_mc_len),
        .ex_branch_taken  (ex_branch_taken),
        .ex_branch_target (ex_branch_target),
        .mem_exc_req      (mem_exc_req),
        .stall            (stall),
        .flush            (flush),
        .new_pc_valid     (new_pc_valid),
        .new_pc           (new_pc),
        .busy             (busy),
        .stall_cnt        (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mc_rem = 0;
        m_redir  = 1'b0;
        m_cnt    = 32'h0;
    endtask

    // One clock cycle: drive inputs, check combinational/registered outputs, advance model.
    task automatic step(input bit exc, input bit mcs, input int len,
                        input bit br, input logic [31:0] tgt, input bit lu);
        logic [4:0]  e_stall;
        logic [3:0]  e_flush;
        logic        e_npv;
        logic [31:0] e_pc;
        logic        e_busy;
        mem_exc_req      = exc;
        ex_mc_start      = mcs;
        ex_mc_len        = CNT_W'(len);
        ex_branch_taken  = br;
        ex_branch_target = tgt;
        id_load_use      = lu;
        #1;
        e_stall = 5'b0; e_flush = 4'b0; e_npv = 1'b0; e_pc = 32'h0;
        e_busy  = m_redir || (m_mc_rem > 0);
        if (exc) begin
            e_stall = 5'b00001; e_flush = 4'b0111;
        end else if (m_redir) begin
            e_npv = 1'b1; e_pc = EXCV; e_flush = 4'b0011;
        end else if (m_mc_rem > 0) begin
            e_stall = 5'b00111; e_flush = 4'b0100;
        end else if (mcs && len > 0) begin
            e_stall = 5'b00111; e_flush = 4'b0100;
        end else if (br) begin
            e_npv = 1'b1; e_pc = tgt; e_flush = 4'b0011;
        end else if (lu) begin
            e_stall = 5'b00011; e_flush = 4'b0010;
        end
        chk("stall",        32'(stall),        32'(e_stall));
        chk("flush",        32'(flush),        32'(e_flush));
        chk("new_pc_valid", 32'(new_pc_valid), 32'(e_npv));
        chk("new_pc",       new_pc,            e_pc);
        chk("busy",         32'(busy),         32'(e_busy));
        chk("stall_cnt",    stall_cnt,         m_cnt);
        // Advance model to the next cycle.
        if (exc) begin
            m_redir = 1'b1; m_mc_rem = 0;
        end else if (m_redir) begin
            m_redir = 1'b0;
        end else if (m_mc_rem > 0) begin
            m_mc_rem--;
        end else if (mcs && len > 0) begin
            m_mc_rem = len - 1;
        end
        if (e_stall[0] && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 32'h0, 0);
    endtask

    initial begin
        rst = 1'b1;
        id_load_use = 0; ex_mc_start = 0; ex_mc_len = '0;
        ex_branch_taken = 0; ex_branch_target = 32'h0; mem_exc_req = 0;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset state, idle outputs.
        idle(2);

        // Load-use for two cycles -> stall_cnt = 2.
        step(0, 0, 0, 0, 32'h0, 1);
        step(0, 0, 0, 0, 32'h0, 1);
        idle(1);
        chk("lu_stall_cnt", stall_cnt, 32'd2);

        // MC L=4, then L=1, then L=0.
        step(0, 1, 4, 0, 32'h0, 0);
        idle(4);
        step(0, 1, 1, 0, 32'h0, 0);
        idle(1);
        step(0, 1, 0, 0, 32'h0, 0);
        idle(1);

        // Branch beats load-use.
        step(0, 0, 0, 1, 32'h0000_1000, 1);
        idle(1);

        // Exception in third cycle of an L=6 op.
        step(0, 1, 6, 0, 32'h0, 0);
        step(0, 0, 0, 0, 32'h0, 0);
        step(1, 0, 0, 0, 32'h0, 0);
        idle(3);

        // Reset asserted in the third cycle of an L=5 op.
        step(0, 1, 5, 0, 32'h0, 0);
        step(0, 0, 0, 0, 32'h0, 0);
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_stall",     32'(stall),     32'h0);
        chk("rst_flush",     32'(flush),     32'h0);
        chk("rst_busy",      32'(busy),      32'h0);
        chk("rst_stall_cnt", stall_cnt,      32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(3);

        // Counter saturation from a preloaded value.
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        m_cnt = 32'hFFFF_FFFE;
        step(0, 0, 0, 0, 32'h0, 1);
        step(0, 0, 0, 0, 32'h0, 1);
        step(0, 0, 0, 0, 32'h0, 1);
        idle(1);
        chk("sat_stall_cnt", stall_cnt, 32'hFFFF_FFFF);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 5) == 0),
                 int'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) == 0),
                 $urandom,
                 ($urandom_range(0, 2) == 0));
        end
        idle(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
